// File: rtl/ft_pkg.sv
// ft_pkg: shared lockstep FSM states and legal redundancy levels
package ft_pkg;
  typedef enum logic [1:0] {RUN, RECOVER, WAIT_ACK} state_e;
  localparam int NUM_CH_DMR = 2;
  localparam int NUM_CH_TMR = 3;
endpackage

// File: rtl/lockstep_vote.sv
// lockstep_vote: combinational compare/vote of redundant write tuples
module lockstep_vote
  import ft_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_CH-1:0]                 we,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data,
  output logic                              v_we,
  output logic [ADDR_WIDTH-1:0]             v_addr,
  output logic [DATA_WIDTH-1:0]             v_data,
  output logic                              mismatch,
  output logic                              unrec,
  output logic [NUM_CH-1:0]                 fault
);
  localparam int TW = 1 + ADDR_WIDTH + DATA_WIDTH;
  logic [NUM_CH-1:0][TW-1:0] t;
  logic [TW-1:0] sel;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tup
    assign t[g] = {we[g], addr[g], data[g]};
  end
  assign {v_we, v_addr, v_data} = sel;
  if (NUM_CH == NUM_CH_TMR) begin : g_tmr
    logic e01, e02, e12;
    assign e01 = t[0] == t[1];
    assign e02 = t[0] == t[2];
    assign e12 = t[1] == t[2];
    // channel 1 carries the majority only when it agrees with 2 against 0
    assign sel      = (e01 | e02 | ~e12) ? t[0] : t[1];
    assign mismatch = ~(e01 & e02);
    assign unrec    = ~(e01 | e02 | e12);
    assign fault    = unrec ? '1 : {e01 & ~e02, e02 & ~e01, e12 & ~e01};
  end else begin : g_dmr
    assign sel      = t[0];
    assign mismatch = t[0] != t[1];
    assign unrec    = mismatch;
    assign fault    = {NUM_CH{mismatch}};
  end
endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: registered voted write path with fault tracking and recovery FSM
module lockstep_checker
  import ft_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_CH-1:0]                 we_i,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_i,
  input  logic                              recover_ack_i,
  input  logic                              clear_i,
  output logic                              we_o,
  output logic [ADDR_WIDTH-1:0]             addr_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              error_o,
  output logic [NUM_CH-1:0]                 fault_mask_o,
  output logic [CNT_WIDTH-1:0]              err_cnt_o,
  output logic                              recover_req_o
);
  if (NUM_CH != NUM_CH_DMR && NUM_CH != NUM_CH_TMR) begin : g_bad_num_ch
    $error("lockstep_checker: NUM_CH must be 2 or 3");
  end
  state_e state, state_nxt;
  logic v_we, mismatch, unrec, compare, err, fwd;
  logic [ADDR_WIDTH-1:0] v_addr;
  logic [DATA_WIDTH-1:0] v_data;
  logic [NUM_CH-1:0] fault, mask_base;
  logic [CNT_WIDTH-1:0] cnt_base;
  lockstep_vote #(.NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_vote (
    .we(we_i), .addr(addr_i), .data(data_i),
    .v_we(v_we), .v_addr(v_addr), .v_data(v_data),
    .mismatch(mismatch), .unrec(unrec), .fault(fault)
  );
  assign compare   = state == RUN && |we_i;
  assign err       = compare & mismatch;
  assign fwd       = compare & ~unrec & v_we;
  // clear is applied first so a same-cycle error lands on a cleared base
  assign mask_base = clear_i ? '0 : fault_mask_o;
  assign cnt_base  = clear_i ? '0 : err_cnt_o;
  always_comb begin
    state_nxt = state;
    state_nxt = state == RUN     ? ((err && unrec) ? RECOVER : RUN) :
                state == RECOVER ? WAIT_ACK :
                recover_ack_i    ? RUN : WAIT_ACK;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= RUN;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_o          <= 1'b0;
      addr_o        <= '0;
      data_o        <= '0;
      error_o       <= 1'b0;
      fault_mask_o  <= '0;
      err_cnt_o     <= '0;
      recover_req_o <= 1'b0;
    end else begin
      we_o          <= fwd;
      addr_o        <= fwd ? v_addr : addr_o;
      data_o        <= fwd ? v_data : data_o;
      error_o       <= err;
      fault_mask_o  <= err ? (mask_base | fault) : mask_base;
      err_cnt_o     <= err ? (&cnt_base ? cnt_base : cnt_base + 1'b1) : cnt_base;
      recover_req_o <= state_nxt != RUN;
    end
  end
endmodule

// File: tb/tb_lockstep_checker.sv
// tb_lockstep_checker: directed checks of DMR and TMR (2-bit counter) instances
module tb_lockstep_checker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] d_we;
  logic [1:0][4:0] d_addr;
  logic [1:0][31:0] d_data;
  logic d_ack, d_clr;
  logic d_we_o, d_err_o, d_req_o;
  logic [4:0] d_addr_o;
  logic [31:0] d_data_o;
  logic [1:0] d_mask_o;
  logic [7:0] d_cnt_o;

  logic [2:0] t_we;
  logic [2:0][4:0] t_addr;
  logic [2:0][31:0] t_data;
  logic t_ack, t_clr;
  logic t_we_o, t_err_o, t_req_o;
  logic [4:0] t_addr_o;
  logic [31:0] t_data_o;
  logic [2:0] t_mask_o;
  logic [1:0] t_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  lockstep_checker #(.NUM_CH(2), .ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(8)) u_dmr (
    .clk_i(clk), .rst_ni(rst_n), .we_i(d_we), .addr_i(d_addr), .data_i(d_data),
    .recover_ack_i(d_ack), .clear_i(d_clr), .we_o(d_we_o), .addr_o(d_addr_o),
    .data_o(d_data_o), .error_o(d_err_o), .fault_mask_o(d_mask_o),
    .err_cnt_o(d_cnt_o), .recover_req_o(d_req_o)
  );

  lockstep_checker #(.NUM_CH(3), .ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)) u_tmr (
    .clk_i(clk), .rst_ni(rst_n), .we_i(t_we), .addr_i(t_addr), .data_i(t_data),
    .recover_ack_i(t_ack), .clear_i(t_clr), .we_o(t_we_o), .addr_o(t_addr_o),
    .data_o(t_data_o), .error_o(t_err_o), .fault_mask_o(t_mask_o),
    .err_cnt_o(t_cnt_o), .recover_req_o(t_req_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic e, input logic [1:0] m, input logic [7:0] c, input logic r);
    chk({tag, ".we_o"}, 64'(d_we_o), 64'(we));
    chk({tag, ".addr_o"}, 64'(d_addr_o), 64'(a));
    chk({tag, ".data_o"}, 64'(d_data_o), 64'(d));
    chk({tag, ".error_o"}, 64'(d_err_o), 64'(e));
    chk({tag, ".fault_mask_o"}, 64'(d_mask_o), 64'(m));
    chk({tag, ".err_cnt_o"}, 64'(d_cnt_o), 64'(c));
    chk({tag, ".recover_req_o"}, 64'(d_req_o), 64'(r));
  endtask

  task automatic chk_t(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic e, input logic [2:0] m, input logic [1:0] c, input logic r);
    chk({tag, ".we_o"}, 64'(t_we_o), 64'(we));
    chk({tag, ".addr_o"}, 64'(t_addr_o), 64'(a));
    chk({tag, ".data_o"}, 64'(t_data_o), 64'(d));
    chk({tag, ".error_o"}, 64'(t_err_o), 64'(e));
    chk({tag, ".fault_mask_o"}, 64'(t_mask_o), 64'(m));
    chk({tag, ".err_cnt_o"}, 64'(t_cnt_o), 64'(c));
    chk({tag, ".recover_req_o"}, 64'(t_req_o), 64'(r));
  endtask

  initial begin
    rst_n = 1'b0;
    d_we = '0; d_addr = '0; d_data = '0; d_ack = 1'b0; d_clr = 1'b0;
    t_we = '0; t_addr = '0; t_data = '0; t_ack = 1'b0; t_clr = 1'b0;
    tick; tick;
    chk_d("d_reset", 0, 0, 0, 0, 2'b00, 0, 0);
    chk_t("t_reset", 0, 0, 0, 0, 3'b000, 0, 0);
    rst_n = 1'b1;

    // DMR: matching write
    d_we = 2'b11; d_addr = {5'h03, 5'h03}; d_data = {32'hDEADBEEF, 32'hDEADBEEF};
    tick;
    chk_d("d_match", 1, 5'h03, 32'hDEADBEEF, 0, 2'b00, 0, 0);
    // idle: differing addr/data ignored
    d_we = 2'b00; d_addr = {5'h02, 5'h01}; d_data = {32'h1, 32'h2};
    tick;
    chk_d("d_idle", 0, 5'h03, 32'hDEADBEEF, 0, 2'b00, 0, 0);
    // mismatch on ch1 data
    d_we = 2'b11; d_addr = {5'h03, 5'h03}; d_data = {32'hDEADBEEE, 32'hDEADBEEF};
    tick;
    chk_d("d_mis", 0, 5'h03, 32'hDEADBEEF, 1, 2'b11, 1, 1);
    // RECOVER: inputs and ack ignored
    d_data = {32'hDEADBEEF, 32'hDEADBEEF}; d_ack = 1'b1;
    tick;
    chk_d("d_recover", 0, 5'h03, 32'hDEADBEEF, 0, 2'b11, 1, 1);
    d_ack = 1'b0;
    tick;
    chk_d("d_wait", 0, 5'h03, 32'hDEADBEEF, 0, 2'b11, 1, 1);
    d_ack = 1'b1;
    tick;
    chk_d("d_ack", 0, 5'h03, 32'hDEADBEEF, 0, 2'b11, 1, 0);
    d_ack = 1'b0; d_addr = {5'h07, 5'h07}; d_data = {32'h12345678, 32'h12345678};
    tick;
    chk_d("d_run_again", 1, 5'h07, 32'h12345678, 0, 2'b11, 1, 0);
    d_we = 2'b00; d_clr = 1'b1;
    tick;
    chk_d("d_clear", 0, 5'h07, 32'h12345678, 0, 2'b00, 0, 0);
    d_clr = 1'b0;
    // reset while in WAIT_ACK
    d_we = 2'b11; d_data = {32'h0, 32'h12345678};
    tick;
    chk_d("d_mis2", 0, 5'h07, 32'h12345678, 1, 2'b11, 1, 1);
    d_we = 2'b00;
    tick;
    chk_d("d_wait2", 0, 5'h07, 32'h12345678, 0, 2'b11, 1, 1);
    rst_n = 1'b0;
    tick;
    chk_d("d_rst_wait", 0, 0, 0, 0, 2'b00, 0, 0);
    chk_t("t_rst_mid", 0, 0, 0, 0, 3'b000, 0, 0);
    rst_n = 1'b1; d_ack = 1'b1;
    d_we = 2'b11; d_addr = {5'h09, 5'h09}; d_data = {32'hCAFEF00D, 32'hCAFEF00D};
    tick;
    chk_d("d_ack_in_run", 1, 5'h09, 32'hCAFEF00D, 0, 2'b00, 0, 0);
    d_ack = 1'b0; d_we = 2'b00;

    // TMR with 2-bit counter
    t_we = 3'b111; t_addr = {5'h03, 5'h03, 5'h03}; t_data = {3{32'hAAAA5555}};
    tick;
    chk_t("t_match", 1, 5'h03, 32'hAAAA5555, 0, 3'b000, 0, 0);
    t_addr = {5'h04, 5'h03, 5'h03};
    tick;
    chk_t("t_ch2_addr", 1, 5'h03, 32'hAAAA5555, 1, 3'b100, 1, 0);
    t_addr = {5'h05, 5'h05, 5'h05}; t_data = {32'h22222222, 32'h22222222, 32'h11111111};
    tick;
    chk_t("t_ch0_data", 1, 5'h05, 32'h22222222, 1, 3'b101, 2, 0);
    t_data = {32'h33333333, 32'h44444444, 32'h33333333};
    tick;
    chk_t("t_ch1_data", 1, 5'h05, 32'h33333333, 1, 3'b111, 3, 0);
    t_data = {32'h55555555, 32'h66666666, 32'h66666666};
    tick;
    chk_t("t_sat", 1, 5'h05, 32'h66666666, 1, 3'b111, 3, 0);
    t_clr = 1'b1; t_data = {32'h77777777, 32'h12121212, 32'h77777777};
    tick;
    chk_t("t_clr_err", 1, 5'h05, 32'h77777777, 1, 3'b010, 1, 0);
    t_clr = 1'b0; t_we = 3'b000; t_addr = {5'h01, 5'h02, 5'h03}; t_data = {32'h1, 32'h2, 32'h3};
    tick;
    chk_t("t_idle", 0, 5'h05, 32'h77777777, 0, 3'b010, 1, 0);
    t_we = 3'b100; t_addr = {3{5'h0A}}; t_data = {3{32'h0BADC0DE}};
    tick;
    chk_t("t_we_minority", 0, 5'h05, 32'h77777777, 1, 3'b110, 2, 0);
    t_we = 3'b111; t_addr = {5'h01, 5'h02, 5'h03};
    tick;
    chk_t("t_all_diff", 0, 5'h05, 32'h77777777, 1, 3'b111, 3, 1);
    t_we = 3'b000;
    tick;
    chk_t("t_wait", 0, 5'h05, 32'h77777777, 0, 3'b111, 3, 1);
    t_ack = 1'b1;
    tick;
    chk_t("t_ack", 0, 5'h05, 32'h77777777, 0, 3'b111, 3, 0);
    t_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lockstep_checker.md
LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 Parameter NUM_CH, default 2, meaning redundant channel count; legal values 2 (DMR) and 3 (TMR); any other value is an elaboration error.
REQ-002 Parameter ADDR_WIDTH, default 5, meaning register-file write address width.
REQ-003 Parameter DATA_WIDTH, default 32, meaning write data width.
REQ-004 Parameter CNT_WIDTH, default 8, meaning error counter width.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_ni  in  1  synchronous, active-low reset.
REQ-007 we_i  in  NUM_CH  per-channel write enable.
REQ-008 addr_i  in  NUM_CH x ADDR_WIDTH  per-channel write address, packed array.
REQ-009 data_i  in  NUM_CH x DATA_WIDTH  per-channel write data, packed array.
REQ-010 recover_ack_i  in  1  recovery controller acknowledge.
REQ-011 clear_i  in  1  clears error counter and fault mask.
REQ-012 we_o / addr_o / data_o  out  1 / ADDR_WIDTH / DATA_WIDTH  registered, voted write to register file.
REQ-013 error_o  out  1  one-cycle pulse per detected mismatch.
REQ-014 fault_mask_o  out  NUM_CH  sticky per-channel fault flags.
REQ-015 err_cnt_o  out  CNT_WIDTH  saturating mismatch count.
REQ-016 recover_req_o  out  1  recovery request, level.

Function
REQ-017 Tuple per channel = {we, addr, data}; a compare occurs in a cycle only when state is RUN and at least one we_i bit is 1; with all we_i low, addr/data are don't-care and no error is raised.
REQ-018 All outputs registered; latency from inputs to we_o/addr_o/data_o/error_o is exactly 1 cycle.
REQ-019 DMR, tuples equal: we_o=1, addr_o/data_o = channel 0 values, next cycle.
REQ-020 DMR, tuples differ: we_o=0 (write suppressed), error_o=1, both fault_mask_o bits set, counter +1, state -> RECOVER.
REQ-021 TMR, all three equal: forward channel 0 tuple, no error.
REQ-022 TMR, exactly two equal: forward majority tuple (we_o = majority we), error_o=1, fault_mask_o bit of minority channel set, counter +1, state stays RUN.
REQ-023 TMR, all three differ: we_o=0, error_o=1, all fault_mask_o bits set, counter +1, state -> RECOVER.
REQ-024 FSM states RUN, RECOVER, WAIT_ACK: RUN -> RECOVER on unrecoverable mismatch; RECOVER asserts recover_req_o and moves to WAIT_ACK next cycle; WAIT_ACK holds recover_req_o=1 until recover_ack_i=1, then -> RUN with recover_req_o=0 the following cycle.
REQ-025 In RECOVER and WAIT_ACK: we_o forced 0, inputs not compared, error_o=0, counter unchanged.
REQ-026 recover_ack_i while in RUN or RECOVER is ignored.
REQ-027 addr_o/data_o hold last value whenever we_o=0.
REQ-028 Counter saturates at 2^CNT_WIDTH-1; no wrap.
REQ-029 clear_i=1: counter and fault_mask_o -> 0; same-cycle new error: counter -> 1 and only the new fault bits set (error wins over clear).
REQ-030 clear_i does not affect FSM state or recover_req_o.

Reset
REQ-031 On rst_ni=0 at a clock edge: state RUN, we_o=0, addr_o=0, data_o=0, error_o=0, fault_mask_o=0, err_cnt_o=0, recover_req_o=0.
REQ-032 Reset during RECOVER/WAIT_ACK aborts recovery; first compare occurs on first edge with rst_ni=1.

Structure
REQ-033 Shared package ft_pkg holds the FSM state enum (RUN, RECOVER, WAIT_ACK) and the NUM_CH legal-value constants.
REQ-034 One combinational sub-module, lockstep_vote, takes NUM_CH tuples and returns voted tuple, mismatch, unrecoverable flag and per-channel fault vector; lockstep_checker holds all registers and the FSM.

Verification
REQ-035 DMR, all we=1, addr=5'h03, data=32'hDEADBEEF both channels -> next cycle we_o=1, addr_o=3, data_o=DEADBEEF, error_o=0.
REQ-036 DMR, ch1 data=32'hDEADBEEE -> we_o=0, error_o=1, fault_mask_o=2'b11, err_cnt_o=1, recover_req_o=1 until ack, then RUN.
REQ-037 TMR, ch2 addr=5'h04, others 5'h03 -> we_o=1, addr_o=3, error_o=1, fault_mask_o=3'b100, recover_req_o=0.
REQ-038 CNT_WIDTH=2, four TMR single-channel faults -> err_cnt_o 1,2,3,3; then clear_i with fifth fault same cycle -> err_cnt_o=1.
REQ-039 Reset asserted while in WAIT_ACK -> all outputs zero next cycle; recover_ack_i=1 afterwards in RUN has no effect.
REQ-040 All we_i=0 with differing addr/data -> error_o=0, we_o=0, counter unchanged.
